// File: rtl/alu_issue.sv
// ALU issue stage: decodes RV32I opcode/funct fields into an ALU control word and
// operand pair, then registers them behind a valid/ready handshake with a skid buffer.
`ifndef kSAIL_MICROARCHITECTURE_ALUCTL_AND
`define kSAIL_MICROARCHITECTURE_ALUCTL_AND   4'b0000
`define kSAIL_MICROARCHITECTURE_ALUCTL_OR    4'b0001
`define kSAIL_MICROARCHITECTURE_ALUCTL_ADD   4'b0010
`define kSAIL_MICROARCHITECTURE_ALUCTL_SRL   4'b0011
`define kSAIL_MICROARCHITECTURE_ALUCTL_SLL   4'b0100
`define kSAIL_MICROARCHITECTURE_ALUCTL_SRA   4'b0101
`define kSAIL_MICROARCHITECTURE_ALUCTL_SUB   4'b0110
`define kSAIL_MICROARCHITECTURE_ALUCTL_SLT   4'b0111
`define kSAIL_MICROARCHITECTURE_ALUCTL_XOR   4'b1000
`define kSAIL_MICROARCHITECTURE_ALUCTL_CSRRW 4'b1001
`define kSAIL_MICROARCHITECTURE_ALUCTL_CSRRS 4'b1010
`define kSAIL_MICROARCHITECTURE_ALUCTL_CSRRC 4'b1011
`define kSAIL_MICROARCHITECTURE_ALUCTL_NOBR  3'b000
`define kSAIL_MICROARCHITECTURE_ALUCTL_BEQ   3'b001
`define kSAIL_MICROARCHITECTURE_ALUCTL_BNE   3'b010
`define kSAIL_MICROARCHITECTURE_ALUCTL_BLT   3'b011
`define kSAIL_MICROARCHITECTURE_ALUCTL_BGE   3'b100
`define kSAIL_MICROARCHITECTURE_ALUCTL_BLTU  3'b101
`define kSAIL_MICROARCHITECTURE_ALUCTL_BGEU  3'b110
`endif

module alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_5,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_aluctl,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   logic [3:0]      dec_op;
   logic [2:0]      dec_br;
   logic [XLEN-1:0] dec_a, dec_b;
   logic            dec_ill;

   always_comb begin
      dec_op  = `kSAIL_MICROARCHITECTURE_ALUCTL_ADD;
      dec_br  = `kSAIL_MICROARCHITECTURE_ALUCTL_NOBR;
      dec_a   = '0;
      dec_b   = '0;
      dec_ill = 1'b0;
      case (in_opcode)
         OPC_OP, OPC_OPIMM: begin
            dec_a = in_rs1;
            dec_b = (in_opcode == OPC_OP) ? in_rs2 : in_imm;
            case (in_funct3)
               3'b000: dec_op = (in_opcode == OPC_OP && in_funct7_5) ?
                                `kSAIL_MICROARCHITECTURE_ALUCTL_SUB : `kSAIL_MICROARCHITECTURE_ALUCTL_ADD;
               3'b001: dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_SLL;
               3'b010: dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_SLT;
               3'b011: begin
                  // Unsigned compare reuses SLT with the BLTU code as a marker.
                  dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_SLT;
                  dec_br = `kSAIL_MICROARCHITECTURE_ALUCTL_BLTU;
               end
               3'b100: dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_XOR;
               3'b101: dec_op = in_funct7_5 ?
                                `kSAIL_MICROARCHITECTURE_ALUCTL_SRA : `kSAIL_MICROARCHITECTURE_ALUCTL_SRL;
               3'b110: dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_OR;
               default: dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_AND;
            endcase
         end
         OPC_LUI: dec_b = in_imm;
         OPC_AUIPC, OPC_JAL: begin
            dec_a = in_pc;
            dec_b = in_imm;
         end
         OPC_JALR, OPC_LOAD, OPC_STORE: begin
            dec_a = in_rs1;
            dec_b = in_imm;
         end
         OPC_BRANCH: begin
            dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_SUB;
            dec_a  = in_rs1;
            dec_b  = in_rs2;
            case (in_funct3)
               3'b000:  dec_br = `kSAIL_MICROARCHITECTURE_ALUCTL_BEQ;
               3'b001:  dec_br = `kSAIL_MICROARCHITECTURE_ALUCTL_BNE;
               3'b100:  dec_br = `kSAIL_MICROARCHITECTURE_ALUCTL_BLT;
               3'b101:  dec_br = `kSAIL_MICROARCHITECTURE_ALUCTL_BGE;
               3'b110:  dec_br = `kSAIL_MICROARCHITECTURE_ALUCTL_BLTU;
               3'b111:  dec_br = `kSAIL_MICROARCHITECTURE_ALUCTL_BGEU;
               default: dec_ill = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
            dec_a = in_funct3[2] ? in_imm : in_rs1;
            dec_b = in_rs2;
            case (in_funct3[1:0])
               2'b01:   dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_CSRRW;
               2'b10:   dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_CSRRS;
               2'b11:   dec_op = `kSAIL_MICROARCHITECTURE_ALUCTL_CSRRC;
               default: dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_op = '0;
         dec_br = '0;
         dec_a  = '0;
         dec_b  = '0;
      end
   end

   logic            or_valid_q, or_valid_d, sk_valid_q, sk_valid_d, in_ready_q;
   logic [6:0]      or_ctl_q, or_ctl_d, sk_ctl_q, sk_ctl_d;
   logic [XLEN-1:0] or_a_q, or_a_d, or_b_q, or_b_d, sk_a_q, sk_a_d, sk_b_q, sk_b_d;
   logic            or_ill_q, or_ill_d, sk_ill_q, sk_ill_d;
   logic            accept, drain;

   assign accept = in_valid && in_ready_q && !flush;
   assign drain  = or_valid_q && out_ready;

   always_comb begin
      or_valid_d = or_valid_q;
      or_ctl_d   = or_ctl_q;
      or_a_d     = or_a_q;
      or_b_d     = or_b_q;
      or_ill_d   = or_ill_q;
      sk_valid_d = sk_valid_q;
      sk_ctl_d   = sk_ctl_q;
      sk_a_d     = sk_a_q;
      sk_b_d     = sk_b_q;
      sk_ill_d   = sk_ill_q;
      if (flush) begin
         or_valid_d = 1'b0;
         sk_valid_d = 1'b0;
      end else if (drain && sk_valid_q) begin
         // in_ready is low whenever SK is full, so no accept can collide here.
         or_valid_d = 1'b1;
         or_ctl_d   = sk_ctl_q;
         or_a_d     = sk_a_q;
         or_b_d     = sk_b_q;
         or_ill_d   = sk_ill_q;
         sk_valid_d = 1'b0;
      end else if (accept && (!or_valid_q || drain)) begin
         or_valid_d = 1'b1;
         or_ctl_d   = {dec_br, dec_op};
         or_a_d     = dec_a;
         or_b_d     = dec_b;
         or_ill_d   = dec_ill;
      end else if (accept) begin
         sk_valid_d = 1'b1;
         sk_ctl_d   = {dec_br, dec_op};
         sk_a_d     = dec_a;
         sk_b_d     = dec_b;
         sk_ill_d   = dec_ill;
      end else if (drain) begin
         or_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         or_valid_q <= 1'b0;
         or_ctl_q   <= '0;
         or_a_q     <= '0;
         or_b_q     <= '0;
         or_ill_q   <= 1'b0;
         sk_valid_q <= 1'b0;
         sk_ctl_q   <= '0;
         sk_a_q     <= '0;
         sk_b_q     <= '0;
         sk_ill_q   <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         or_valid_q <= or_valid_d;
         or_ctl_q   <= or_ctl_d;
         or_a_q     <= or_a_d;
         or_b_q     <= or_b_d;
         or_ill_q   <= or_ill_d;
         sk_valid_q <= sk_valid_d;
         sk_ctl_q   <= sk_ctl_d;
         sk_a_q     <= sk_a_d;
         sk_b_q     <= sk_b_d;
         sk_ill_q   <= sk_ill_d;
         in_ready_q <= !sk_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = or_valid_q;
   assign out_aluctl  = or_ctl_q;
   assign out_a       = or_a_q;
   assign out_b       = or_b_q;
   assign out_illegal = or_ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, skid stall, flush, reset.
module tb_alu_issue;

   localparam logic [3:0] C_ADD = 4'b0010, C_SUB = 4'b0110, C_SLT = 4'b0111, C_SRA = 4'b0101;
   localparam logic [3:0] C_CSRRW = 4'b1001, C_CSRRC = 4'b1011;
   localparam logic [2:0] B_NO = 3'b000, B_BEQ = 3'b001, B_BNE = 3'b010, B_BLTU = 3'b101;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, in_funct7_5;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
   logic        out_valid, out_ready, out_illegal;
   logic [6:0]  out_aluctl;
   logic [31:0] out_a, out_b;
   int          errors = 0;
   int          checks = 0;

   alu_issue #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_aluctl(out_aluctl), .out_a(out_a), .out_b(out_b), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc);
      in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
   endtask

   task automatic chk_word(input string tag, input logic [6:0] ctl,
                           input logic [31:0] a, input logic [31:0] b, input logic ill);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_ctl"}, {25'd0, out_aluctl}, {25'd0, ctl});
      chk({tag, "_a"}, out_a, a);
      chk({tag, "_b"}, out_b, b);
      chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
      $display("txn %s ctl=%h a=%h b=%h ill=%b", tag, out_aluctl, out_a, out_b, out_illegal);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      in_valid = 1'b0;
      step(); step();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_ctl", {25'd0, out_aluctl}, 32'd0);
      chk("rst_a", out_a, 32'd0);
      chk("rst_b", out_b, 32'd0);
      chk("rst_ill", {31'd0, out_illegal}, 32'd0);

      rst_n = 1'b1; step();
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

      // Throughput with out_ready high: one word per cycle.
      out_ready = 1'b1;
      drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 32'd0); step();
      chk_word("add", {B_NO, C_ADD}, 32'd5, 32'd7, 1'b0);
      drive(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd99, 32'd0); step();
      chk_word("sub", {B_NO, C_SUB}, 32'd5, 32'd7, 1'b0);
      drive(7'b1100011, 3'b000, 1'b0, 32'd3, 32'd3, 32'h10, 32'd0); step();
      chk_word("beq", {B_BEQ, C_SUB}, 32'd3, 32'd3, 1'b0);
      drive(7'b1100011, 3'b001, 1'b0, 32'd3, 32'd3, 32'h10, 32'd0); step();
      chk_word("bne", {B_BNE, C_SUB}, 32'd3, 32'd3, 1'b0);
      drive(7'b1100011, 3'b110, 1'b0, 32'd3, 32'd3, 32'h10, 32'd0); step();
      chk_word("bltu", {B_BLTU, C_SUB}, 32'd3, 32'd3, 1'b0);
      drive(7'b0010111, 3'b000, 1'b0, 32'd1, 32'd2, 32'h2000, 32'h100); step();
      chk_word("auipc", {B_NO, C_ADD}, 32'h100, 32'h2000, 1'b0);
      drive(7'b0110111, 3'b000, 1'b0, 32'd1, 32'd2, 32'hABCDE000, 32'h100); step();
      chk_word("lui", {B_NO, C_ADD}, 32'd0, 32'hABCDE000, 1'b0);
      drive(7'b0010011, 3'b011, 1'b0, 32'd8, 32'd2, 32'h40, 32'd0); step();
      chk_word("sltiu", {B_BLTU, C_SLT}, 32'd8, 32'h40, 1'b0);
      drive(7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'd2, 32'd4, 32'd0); step();
      chk_word("srai", {B_NO, C_SRA}, 32'h80000000, 32'd4, 1'b0);
      drive(7'b0010011, 3'b000, 1'b1, 32'd6, 32'd2, 32'd4, 32'd0); step();
      chk_word("addi_f7", {B_NO, C_ADD}, 32'd6, 32'd4, 1'b0);
      drive(7'b1100011, 3'b010, 1'b0, 32'd3, 32'd4, 32'd5, 32'd0); step();
      chk_word("br_f3_010", 7'd0, 32'd0, 32'd0, 1'b1);
      drive(7'b1110011, 3'b001, 1'b0, 32'h55, 32'h66, 32'h1F, 32'd0); step();
      chk_word("csrrw", {B_NO, C_CSRRW}, 32'h55, 32'h66, 1'b0);
      in_valid = 1'b0; step();
      chk("drained_valid", {31'd0, out_valid}, 32'd0);

      // Stall: I1 to OR, I2 to SK, I3 held off until SK empties.
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 32'h11, 32'd1, 32'd0, 32'd0); step();
      chk("st1_a", out_a, 32'h11);
      chk("st1_ready", {31'd0, in_ready}, 32'd1);
      drive(7'b0110011, 3'b000, 1'b0, 32'h22, 32'd1, 32'd0, 32'd0); step();
      chk("st2_a", out_a, 32'h11);
      chk("st2_ready", {31'd0, in_ready}, 32'd0);
      drive(7'b0110011, 3'b000, 1'b0, 32'h33, 32'd1, 32'd0, 32'd0); step();
      chk("st3_a_held", out_a, 32'h11);
      chk("st3_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1; step();
      chk_word("deliver_i2", {B_NO, C_ADD}, 32'h22, 32'd1, 1'b0);
      chk("st4_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk_word("deliver_i3", {B_NO, C_ADD}, 32'h33, 32'd1, 1'b0);
      in_valid = 1'b0; step();
      chk("st_empty", {31'd0, out_valid}, 32'd0);

      // Flush with OR+SK full, then flush dropping an input that would be accepted.
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 32'h44, 32'd1, 32'd0, 32'd0); step();
      drive(7'b0110011, 3'b000, 1'b0, 32'h55, 32'd1, 32'd0, 32'd0); step();
      chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
      flush = 1'b1;
      drive(7'b0110011, 3'b000, 1'b0, 32'h66, 32'd1, 32'd0, 32'd0); step();
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_ready", {31'd0, in_ready}, 32'd1);
      drive(7'b0110011, 3'b000, 1'b0, 32'h77, 32'd1, 32'd0, 32'd0); step();
      chk("fl2_valid", {31'd0, out_valid}, 32'd0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
      chk("fl_after_valid", {31'd0, out_valid}, 32'd0);

      // Illegal opcode still flows; CSRRCI uses zimm as A.
      drive(7'b1111111, 3'b000, 1'b0, 32'd9, 32'd9, 32'd9, 32'd9); step();
      chk_word("illegal", 7'd0, 32'd0, 32'd0, 1'b1);
      drive(7'b1110011, 3'b111, 1'b0, 32'h77, 32'hFF, 32'h1F, 32'd0); step();
      chk_word("csrrci", {B_NO, C_CSRRC}, 32'h1F, 32'hFF, 1'b0);

      // Reset mid-stall drops everything.
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 32'h88, 32'd1, 32'd0, 32'd0); step();
      step();
      rst_n = 1'b0; in_valid = 1'b0; step();
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_a", out_a, 32'd0);
      rst_n = 1'b1; out_ready = 1'b1; step();
      chk("mid_rst_after_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_after_ready", {31'd0, in_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

ALU issue stage for the RV32I sail core, the producer end of the ALU control/operand interface. It decodes opcode/funct fields and selects operands for each instruction. It registers the ALU control word and both ALU operands (A, B) behind a valid/ready handshake with a 2-entry skid buffer, so the decode stage and ALU stage can stall independently. A flush input discards in-flight entries on redirects.

## Interface
Parameters:
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  issue stage can accept; transfer when in_valid && in_ready.
- in_opcode  in  7  instruction[6:0].
- in_funct3  in  3  instruction[14:12].
- in_funct7_5  in  1  instruction[30].
- in_rs1  in  32  rs1 read value.
- in_rs2  in  32  rs2 read value; for CSR ops, the current CSR value.
- in_imm  in  32  sign-extended immediate; for CSR*I ops, the zero-extended zimm.
- in_pc  in  32  instruction PC.
- out_valid  out  1  ALU word valid.
- out_ready  in  1  ALU stage accepts; transfer when out_valid && out_ready.
- out_aluctl  out  7  ALUctl; [3:0] and [6:4] use the `kSAIL_MICROARCHITECTURE_ALUCTL_*` defines.
- out_a  out  32  ALU operand A.
- out_b  out  32  ALU operand B.
- out_illegal  out  1  entry carries an unsupported opcode/funct combination.

## Operation
- Decode: combinational, on input fields.
- Field [6:4]: 3'b000 (no branch) for every non-branch op.
- OP (0110011) and OP-IMM (0010011):
  - Operands: A=rs1; B=rs2 (OP) or imm (OP-IMM).
  - funct3 000: ADD; SUB only if OP && funct7_5.
  - funct3 001: SLL.
  - funct3 010: SLT.
  - funct3 011: SLT code, with [6:4]=BLTU code as the unsigned marker.
  - funct3 100: XOR.
  - funct3 101: SRA if funct7_5, else SRL.
  - funct3 110: OR.
  - funct3 111: AND.
- LUI: ADD, A=0, B=imm.
- AUIPC and JAL: ADD, A=pc, B=imm.
- JALR, LOAD, STORE: ADD, A=rs1, B=imm.
- BRANCH:
  - [3:0]=SUB, A=rs1, B=rs2.
  - [6:4] by funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - funct3 010/011 are illegal.
- SYSTEM:
  - funct3 x01 → CSRRW, x10 → CSRRS, x11 → CSRRC.
  - A=rs1 (x=0) or imm (x=1); B=rs2.
  - funct3 000/100 are illegal.
- Illegal/unknown opcode: aluctl=0, A=0, B=0, out_illegal=1. The entry still flows through the handshake.
- Buffering:
  - Output register (OR) plus one skid register (SK).
  - Accept when in_valid && in_ready.
  - If OR is empty, or OR is draining this cycle with SK empty, data loads into OR.
  - Otherwise it loads into SK.
  - When OR drains and SK is full, SK moves to OR the same edge.
- in_ready is a registered signal, equal to !SK_full.

## Timing
- Reset (rst_n=0 at edge):
  - out_valid=0, in_ready=0, out_aluctl=0, out_a=0, out_b=0, out_illegal=0, SK empty.
  - in_ready=1 from the first edge with rst_n=1.
- Latency: an instruction accepted at edge N is on out_* with out_valid=1 after edge N. Throughput is 1/cycle with out_ready held high.
- Stall: with out_ready=0, the first extra accept goes to SK and in_ready drops after that edge. out_* stay stable while out_valid && !out_ready.
- Order: strict FIFO. SK is never bypassed by newer input.
- Simultaneous drain+accept:
  - SK empty: new data replaces OR.
  - SK full: no accept occurs, because in_ready=0.
- Flush:
  - At the edge, OR and SK are invalidated and in_ready goes to 1.
  - An input handshaking in the same cycle is dropped.
  - An output handshaking in the same cycle counts as delivered.
- Reset mid-stall: all entries are lost and the reset values apply.

## Test plan
- Reset, then ADD x (rs1=5, rs2=7, opcode 0110011, f3=000, f7_5=0) → next cycle out_valid=1, aluctl[3:0]=ADD, A=5, B=7; SUB variant gives aluctl[3:0]=SUB.
- Back-to-back BEQ, BNE, BLTU (rs1=3, rs2=3), out_ready=1 → three consecutive out cycles, [3:0]=SUB, [6:4]=BEQ/BNE/BLTU, A=B=3.
- AUIPC pc=0x100, imm=0x2000 → ADD, A=0x100, B=0x2000. LUI imm=0xABCDE000 → A=0, B=0xABCDE000.
- out_ready=0, push I1,I2,I3 → I1 in OR, I2 in SK, in_ready=0 after the 2nd accept, I3 held. Raise out_ready → I1, I2, I3 delivered in order, no loss or duplication.
- Stalled with OR+SK full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Opcode 1111111 → out_illegal=1, aluctl=0, A=B=0. Then CSRRCI (f3=111, imm=0x1F, rs2=0xFF) → CSRRC, A=0x1F, B=0xFF, illegal=0.
